ps2_keyboard: RTL and testbench

PS/2 keyboard receiver and scan-code decoder (Set 2) that produces the `keycode`/`press` pair consumed by the player controllers.
- Synchronizes and filters the PS/2 clock/data lines, deserializes 11-bit frames and checks framing/parity.
- Decodes E0 (extended) and F0 (break) prefixes into make/break events.
- Holds a "current key" state for per-frame polling.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_frame_rx.sv | 125 ++++++++++++
 rtl/ps2_keyboard.sv | 119 +++++++++++
 tb/tb_ps2_keyboard.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] PS2_IGN_NUL    = 8'h00;
  localparam logic [7:0] PS2_IGN_BAT    = 8'hAA;
  localparam logic [7:0] PS2_IGN_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_IGN_ACK    = 8'hFA;
  localparam logic [7:0] PS2_IGN_RESEND = 8'hFE;
  localparam logic [7:0] PS2_IGN_ERR    = 8'hFF;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_PUNCH = 8'h70;
  localparam logic [7:0] KEY_W     = 8'h1D;

  typedef enum logic {
    FR_IDLE,
    FR_SHIFT
  } frame_state_t;

  typedef enum logic [1:0] {
    DEC_WAIT,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  // Controller/status bytes that never map to a key.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_IGN_NUL) || (b == PS2_IGN_BAT) || (b == PS2_IGN_ECHO) ||
           (b == PS2_IGN_ACK) || (b == PS2_IGN_RESEND) || (b == PS2_IGN_ERR);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deserializer with parity, framing
// and timeout checks.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT);

  logic [1:0]        r_clk_sync;
  logic [1:0]        r_dat_sync;
  logic              r_filt;
  logic              r_filt_d;
  logic [FILT_W-1:0] r_filt_cnt;
  logic              r_fall;

  frame_state_t      r_state;
  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_start;
  logic              r_parity;
  logic [TO_W-1:0]   r_to_cnt;

  logic              w_dat;
  logic              w_to_hit;

  assign w_dat    = r_dat_sync[1];
  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Lines idle high, so the conditioning chain resets to 1 to avoid a phantom edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      r_filt_d   <= r_filt;
      r_fall     <= r_filt_d & ~r_filt;
      if (r_clk_sync[1] == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        r_filt     <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= FR_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_start      <= 1'b0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (r_fall) begin
        r_to_cnt <= '0;
      end else if ((r_state == FR_SHIFT) && !w_to_hit) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      case (r_state)
        FR_IDLE: begin
          if (r_fall) begin
            r_start   <= w_dat;
            r_bit_cnt <= 4'd1;
            r_state   <= FR_SHIFT;
          end
        end
        FR_SHIFT: begin
          if (r_fall) begin
            if (r_bit_cnt <= 4'd8) begin
              r_shift <= {w_dat, r_shift[7:1]};
            end else if (r_bit_cnt == 4'd9) begin
              r_parity <= w_dat;
            end
            if (r_bit_cnt == 4'd10) begin
              // Odd parity: data bits plus parity bit must hold an odd count of ones.
              if (!r_start && w_dat && (^{r_shift, r_parity})) begin
                o_byte       <= r_shift;
                o_byte_valid <= 1'b1;
              end else begin
                o_frame_err <= 1'b1;
              end
              r_bit_cnt <= '0;
              r_state   <= FR_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (w_to_hit) begin
            o_frame_err <= 1'b1;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_state     <= FR_IDLE;
          end
        end
        default: r_state <= FR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 Set 2 keyboard receiver: turns scan-code bytes into make/break events
// and tracks the currently held key for per-frame polling.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       press,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_make,
  output logic       ev_valid,
  output logic       frame_err
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;
  logic       w_emit;
  logic       w_ext;
  logic       w_make;
  dec_state_t w_dec_next;
  dec_state_t r_dec;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_frame_rx (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  assign frame_err = w_frame_err;

  // Prefix tracking; a framing error drops any pending E0/F0 prefix.
  always_comb begin
    w_dec_next = r_dec;
    w_emit     = 1'b0;
    w_ext      = 1'b0;
    w_make     = 1'b0;
    if (w_frame_err) begin
      w_dec_next = DEC_WAIT;
    end else if (w_byte_valid) begin
      case (r_dec)
        DEC_WAIT: begin
          if (w_byte == PS2_EXT) begin
            w_dec_next = DEC_EXT;
          end else if (w_byte == PS2_BRK) begin
            w_dec_next = DEC_BRK;
          end else if (!is_ignored(w_byte)) begin
            w_emit = 1'b1;
            w_make = 1'b1;
          end
        end
        DEC_EXT: begin
          if (w_byte == PS2_BRK) begin
            w_dec_next = DEC_EXT_BRK;
          end else if (w_byte != PS2_EXT) begin
            w_emit     = 1'b1;
            w_make     = 1'b1;
            w_ext      = 1'b1;
            w_dec_next = DEC_WAIT;
          end
        end
        DEC_BRK: begin
          w_emit     = 1'b1;
          w_dec_next = DEC_WAIT;
        end
        DEC_EXT_BRK: begin
          w_emit     = 1'b1;
          w_ext      = 1'b1;
          w_dec_next = DEC_WAIT;
        end
        default: w_dec_next = DEC_WAIT;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dec    <= DEC_WAIT;
      keycode  <= '0;
      extended <= 1'b0;
      press    <= 1'b0;
      ev_code  <= '0;
      ev_ext   <= 1'b0;
      ev_make  <= 1'b0;
      ev_valid <= 1'b0;
    end else begin
      r_dec    <= w_dec_next;
      ev_valid <= w_emit;
      if (w_emit) begin
        ev_code <= w_byte;
        ev_ext  <= w_ext;
        ev_make <= w_make;
        if (w_make) begin
          keycode  <= w_byte;
          extended <= w_ext;
          press    <= 1'b1;
        end else if ({w_ext, w_byte} == {extended, keycode}) begin
          press <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: bit-bangs PS/2 frames and checks events and held-key state.
module tb_ps2_keyboard;

  localparam int unsigned TB_TIMEOUT = 1000;
  localparam int          HALF       = 8;

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       extended;
  logic       press;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_make;
  logic       ev_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_cnt   = 0;
  int err_cnt  = 0;
  int dbl_cnt  = 0;
  logic ev_valid_d = 1'b0;

  ps2_keyboard #(
    .FILTER_LEN (4),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .extended  (extended),
    .press     (press),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_make   (ev_make),
    .ev_valid  (ev_valid),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge Clk) begin
    if (ev_valid) ev_cnt++;
    if (frame_err) err_cnt++;
    if (ev_valid && ev_valid_d) dbl_cnt++;
    ev_valid_d = ev_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge Clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int rst_at);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      if (i == rst_at) begin
        wait_clks(2);
        Reset = 1'b1;
        wait_clks(2);
        #1;
        check("rst_keycode", 32'(keycode), 32'h0);
        check("rst_press", 32'(press), 32'h0);
        check("rst_extended", 32'(extended), 32'h0);
        check("rst_ev_code", 32'(ev_code), 32'h0);
        check("rst_ev_make", 32'(ev_make), 32'h0);
        check("rst_ev_valid", 32'(ev_valid), 32'h0);
        Reset = 1'b0;
        wait_clks(HALF - 4);
      end else begin
        wait_clks(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clks(4 * HALF);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11, -1);
  endtask

  int e0;
  int f0;

  initial begin
    wait_clks(5);
    #1;
    Reset = 1'b0;
    wait_clks(5);
    #1;
    check("reset_keycode", 32'(keycode), 32'h0);
    check("reset_press", 32'(press), 32'h0);
    check("reset_extended", 32'(extended), 32'h0);
    check("reset_ev_code", 32'(ev_code), 32'h0);

    // Single make 0x6B; parity bit must be 0 for this byte.
    check("frame_6b_parity", 32'(mk_frame(8'h6B, 1'b0)), 32'h40_6 | 32'h0D6);
    e0 = ev_cnt;
    send_byte(8'h6B);
    check("make6b_events", 32'(ev_cnt - e0), 32'd1);
    check("make6b_ev_code", 32'(ev_code), 32'h6B);
    check("make6b_ev_make", 32'(ev_make), 32'h1);
    check("make6b_ev_ext", 32'(ev_ext), 32'h0);
    check("make6b_keycode", 32'(keycode), 32'h6B);
    check("make6b_press", 32'(press), 32'h1);

    // Break of the held key.
    e0 = ev_cnt;
    send_byte(8'hF0);
    send_byte(8'h6B);
    check("brk6b_events", 32'(ev_cnt - e0), 32'd1);
    check("brk6b_ev_code", 32'(ev_code), 32'h6B);
    check("brk6b_ev_make", 32'(ev_make), 32'h0);
    check("brk6b_press", 32'(press), 32'h0);
    check("brk6b_keycode", 32'(keycode), 32'h6B);

    // Extended make then extended break.
    e0 = ev_cnt;
    send_byte(8'hE0);
    send_byte(8'h74);
    check("extmk_events", 32'(ev_cnt - e0), 32'd1);
    check("extmk_keycode", 32'(keycode), 32'h74);
    check("extmk_extended", 32'(extended), 32'h1);
    check("extmk_press", 32'(press), 32'h1);
    check("extmk_ev_ext", 32'(ev_ext), 32'h1);
    e0 = ev_cnt;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    check("extbrk_events", 32'(ev_cnt - e0), 32'd1);
    check("extbrk_ev_make", 32'(ev_make), 32'h0);
    check("extbrk_ev_ext", 32'(ev_ext), 32'h1);
    check("extbrk_press", 32'(press), 32'h0);

    // Break of a key that is no longer the held one.
    e0 = ev_cnt;
    send_byte(8'h6B);
    send_byte(8'h74);
    send_byte(8'hF0);
    send_byte(8'h6B);
    check("nomatch_events", 32'(ev_cnt - e0), 32'd3);
    check("nomatch_keycode", 32'(keycode), 32'h74);
    check("nomatch_extended", 32'(extended), 32'h0);
    check("nomatch_press", 32'(press), 32'h1);
    check("nomatch_ev_code", 32'(ev_code), 32'h6B);
    check("nomatch_ev_make", 32'(ev_make), 32'h0);

    // Bad parity, then recovery.
    e0 = ev_cnt;
    f0 = err_cnt;
    send_bits(mk_frame(8'h74, 1'b1), 11, -1);
    check("badpar_errs", 32'(err_cnt - f0), 32'd1);
    check("badpar_events", 32'(ev_cnt - e0), 32'd0);
    send_byte(8'h70);
    check("recover_keycode", 32'(keycode), 32'h70);
    check("recover_press", 32'(press), 32'h1);

    // Typematic repeat still pulses an event; ignored byte does not.
    e0 = ev_cnt;
    send_byte(8'h70);
    check("repeat_events", 32'(ev_cnt - e0), 32'd1);
    check("repeat_press", 32'(press), 32'h1);
    e0 = ev_cnt;
    send_byte(8'hAA);
    check("ignore_events", 32'(ev_cnt - e0), 32'd0);
    check("ignore_keycode", 32'(keycode), 32'h70);

    // Partial frame abandoned by the timeout.
    e0 = ev_cnt;
    f0 = err_cnt;
    send_bits(mk_frame(8'h1D, 1'b0), 5, -1);
    wait_clks(TB_TIMEOUT + 100);
    #1;
    check("timeout_errs", 32'(err_cnt - f0), 32'd1);
    check("timeout_events", 32'(ev_cnt - e0), 32'd0);
    send_byte(8'h6B);
    check("post_to_keycode", 32'(keycode), 32'h6B);
    check("post_to_ev_make", 32'(ev_make), 32'h1);

    // A framing error drops a pending E0 prefix.
    send_byte(8'hE0);
    send_bits(mk_frame(8'h11, 1'b1), 11, -1);
    send_byte(8'h1D);
    check("drop_keycode", 32'(keycode), 32'h1D);
    check("drop_extended", 32'(extended), 32'h0);
    check("drop_ev_ext", 32'(ev_ext), 32'h0);

    // Reset in the middle of a frame.
    e0 = ev_cnt;
    send_bits(mk_frame(8'h74, 1'b0), 11, 6);
    wait_clks(TB_TIMEOUT + 100);
    #1;
    check("midrst_events", 32'(ev_cnt - e0), 32'd0);
    check("midrst_keycode", 32'(keycode), 32'h0);
    check("midrst_press", 32'(press), 32'h0);
    send_byte(8'h74);
    check("after_rst_keycode", 32'(keycode), 32'h74);
    check("after_rst_press", 32'(press), 32'h1);
    check("after_rst_ev_ext", 32'(ev_ext), 32'h0);

    check("ev_valid_single_cycle", 32'(dbl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
